// File: rtl/wb_regfile_sb_pkg.sv
// Shared writeback-path types and sizes for the register file / scoreboard.
package wb_regfile_sb_pkg;

  localparam int unsigned D_SIZE        = 32;
  localparam int unsigned ADDR_LINE_REG = 5;
  localparam int unsigned NREG          = 2 ** ADDR_LINE_REG;

  typedef logic [ADDR_LINE_REG-1:0] reg_addr_t;
  typedef logic [D_SIZE-1:0]        reg_data_t;

  // Registered writeback triple as produced by the memory stage.
  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    reg_data_t data;
  } wb_bus_t;

endpackage

// File: rtl/wb_regfile_sb_pend_cnt.sv
// Pending-write counter for one architectural register.
module sb_pend_cnt
  import wb_regfile_sb_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 3,
  parameter int unsigned CW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] pend,
  output logic          uflow
);

  logic [CW-1:0] pend_q, pend_d;

  always_comb begin
    pend_d = pend_q;
    if (inc && !dec) begin
      pend_d = pend_q + CW'(1);
    end else if (dec && !inc && (pend_q != '0)) begin
      pend_d = pend_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend  = pend_q;
  assign uflow = dec && (pend_q == '0);

endmodule

// File: rtl/wb_regfile_sb.sv
// MEM/WB writeback consumer: register file with write-through bypass reads
// and a per-register pending-write scoreboard driving the ID stall.
// Optional feature macro: STALL_CNT_EN (adds saturating stall_cycles output).
module wb_regfile_sb
  import wb_regfile_sb_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid,
  input  logic [ADDR_LINE_REG-1:0] wb_addr,
  input  logic [D_SIZE-1:0]        wb_data,
  input  logic [ADDR_LINE_REG-1:0] rd_addr_a,
  input  logic [ADDR_LINE_REG-1:0] rd_addr_b,
  input  logic                     use_a,
  input  logic                     use_b,
  input  logic                     iss_valid,
  input  logic                     iss_wr,
  input  logic [ADDR_LINE_REG-1:0] iss_dest,
  output logic [D_SIZE-1:0]        rd_data_a,
  output logic [D_SIZE-1:0]        rd_data_b,
  output logic                     stall,
  output logic                     sb_err
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]              stall_cycles
`endif
);

  localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);

  wb_bus_t       wb;
  reg_data_t     regs_q [NREG];
  reg_data_t     regs_d [NREG];
  logic [CW-1:0] pend   [NREG];
  logic [NREG-1:0] uflow;
  logic          wb_wr, acc, hz_a, hz_b, sat;
  logic          sb_err_q, sb_err_d;

  assign wb    = '{valid: wb_valid, addr: wb_addr, data: wb_data};
  assign wb_wr = wb.valid && (wb.addr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wb_wr) begin
      regs_d[wb.addr] = wb.data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // R0 never written, so regs_q[0] reads back as zero.
  assign rd_data_a = (wb_wr && (wb.addr == rd_addr_a)) ? wb.data : regs_q[rd_addr_a];
  assign rd_data_b = (wb_wr && (wb.addr == rd_addr_b)) ? wb.data : regs_q[rd_addr_b];

  assign pend[0]  = '0;
  assign uflow[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_pend
    sb_pend_cnt #(
      .MAX_INFLIGHT (MAX_INFLIGHT),
      .CW           (CW)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (acc && (iss_dest == ADDR_LINE_REG'(r))),
      .dec   (wb.valid && (wb.addr == ADDR_LINE_REG'(r))),
      .pend  (pend[r]),
      .uflow (uflow[r])
    );
  end

  // A last outstanding write being retired this cycle is covered by the bypass.
  always_comb begin
    hz_a  = use_a && (rd_addr_a != '0) && (pend[rd_addr_a] != '0)
            && !((pend[rd_addr_a] == CW'(1)) && wb_wr && (wb.addr == rd_addr_a));
    hz_b  = use_b && (rd_addr_b != '0) && (pend[rd_addr_b] != '0)
            && !((pend[rd_addr_b] == CW'(1)) && wb_wr && (wb.addr == rd_addr_b));
    sat   = iss_valid && iss_wr && (iss_dest != '0)
            && (pend[iss_dest] == CW'(MAX_INFLIGHT))
            && !(wb_wr && (wb.addr == iss_dest));
    stall = iss_valid && (hz_a || hz_b || sat);
    acc   = iss_valid && !stall && iss_wr && (iss_dest != '0);
  end

  always_comb begin
    sb_err_d = sb_err_q | (|uflow);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_err_q <= 1'b0;
    end else begin
      sb_err_q <= sb_err_d;
    end
  end

  assign sb_err = sb_err_q;

`ifdef STALL_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule
